// File: rtl/command_encoder_pkg.sv
// command_encoder_pkg
// Shared constants for the command encoder slice: how many command lines
// exist, how wide an opcode byte is, the legal opcode range and the
// mapping from a command index to the opcode byte that represents it.
package command_encoder_pkg;

  localparam int NUM_CMDS  = 16;
  localparam int OPC_WIDTH = 8;

  localparam logic [OPC_WIDTH-1:0] OPC_MIN = 8'h01;
  localparam logic [OPC_WIDTH-1:0] OPC_MAX = 8'h10;

  // Command i is sent as opcode i + OPC_OFFSET, so opcode 8'h00 never
  // appears on the wire and can mean "nothing valid".
  localparam int OPC_OFFSET = 1;

  function automatic logic [OPC_WIDTH-1:0] idx_to_opcode(input int idx);
    return OPC_WIDTH'(idx + OPC_OFFSET);
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo
// Small synchronous FIFO holding encoded opcode bytes.
// Ports:
//   clk, reset  : system clock, synchronous active-high reset
//   push        : write push_data this edge (ignored when full with no pop)
//   push_data   : byte to enqueue
//   pop         : advance the read pointer this edge (ignored when empty)
//   head        : byte at the head, 0 when empty
//   empty, full : occupancy flags
//   count       : number of stored bytes, 0..DEPTH
module cmd_fifo
  import command_encoder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = OPC_WIDTH,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);

  // When full, a push is only accepted alongside a pop; the write then
  // lands in the slot the pop is vacating.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign head = empty ? '0 : mem[rd_ptr];

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/command_encoder.sv
// command_encoder
// Collects one-cycle command request pulses into a pending register and
// turns them, lowest index first and one per cycle, into opcode bytes
// (index + 1) queued in a FIFO for a valid/ack sink.
// Ports:
//   clk, reset  : system clock, synchronous active-high reset
//   cmd_req     : request pulses, bit i requests command i
//   data_out    : opcode at FIFO head, 8'h00 when empty
//   data_valid  : FIFO holds at least one byte
//   data_ack    : sink takes data_out when data_valid is also high
//   busy        : requests pending or bytes queued
//   overrun     : sticky, a request hit an already pending command
//   clr_err     : pulse clearing overrun (a new overrun wins)
module command_encoder
  import command_encoder_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_CMDS-1:0]  cmd_req,
  output logic [OPC_WIDTH-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ack,
  output logic                 busy,
  output logic                 overrun,
  input  logic                 clr_err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_CMDS-1:0]  pending;
  logic [NUM_CMDS-1:0]  pick_mask;
  logic [NUM_CMDS-1:0]  clear_mask;
  logic [OPC_WIDTH-1:0] pick_opc;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic [CW-1:0]        fifo_count;
  logic                 pop;
  logic                 push;
  logic                 overrun_event;
  logic                 overrun_q;

  assign pop  = data_valid && data_ack;
  assign push = (|pending) && (!fifo_full || pop);

  // Two's-complement trick isolates the lowest set pending bit.
  assign pick_mask  = pending & (~pending + NUM_CMDS'(1));
  assign clear_mask = push ? pick_mask : '0;

  // Scanning downward lets the lowest set index overwrite higher ones.
  always_comb begin
    pick_opc = '0;
    for (int i = NUM_CMDS - 1; i >= 0; i--) begin
      if (pending[i]) pick_opc = idx_to_opcode(i);
    end
  end

  // A request landing on a bit that is being pushed this cycle re-arms it
  // cleanly; only a hit on a bit that stays pending is an overrun.
  assign overrun_event = |(cmd_req & pending & ~clear_mask);

  always_ff @(posedge clk) begin
    if (reset) begin
      pending   <= '0;
      overrun_q <= 1'b0;
    end else begin
      pending <= (pending & ~clear_mask) | cmd_req;
      if (overrun_event)
        overrun_q <= 1'b1;
      else if (clr_err)
        overrun_q <= 1'b0;
    end
  end

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (OPC_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (pick_opc),
    .pop       (pop),
    .head      (data_out),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  assign data_valid = !fifo_empty;
  assign busy       = (|pending) || !fifo_empty;
  assign overrun    = overrun_q;

endmodule

// File: doc/command_encoder.md
COMMAND_ENCODER -- requirements
Module: command_encoder

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of queued opcode bytes (power of two, >=2).
REQ-002 clk  input  1  single system clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cmd_req  input  16  one-cycle request pulses; bit i requests command i.
REQ-005 data_out  output  8  opcode byte at FIFO head; opcode = i+1 (range 8'h01..8'h10).
REQ-006 data_valid  output  1  high while FIFO holds at least one byte.
REQ-007 data_ack  input  1  sink accepts data_out on a cycle where data_valid and data_ack are both high.
REQ-008 busy  output  1  high while any pending bit is set or FIFO is non-empty.
REQ-009 overrun  output  1  sticky error; a request hit an already-pending bit.
REQ-010 clr_err  input  1  one-cycle pulse clears overrun.

Function
REQ-011 Pending register (16 b): bit i set at the clock edge where cmd_req[i]=1.
REQ-012 Each cycle with pending non-zero and push allowed, the lowest-index set bit i is encoded to opcode i+1, written to FIFO, and its pending bit cleared; one push per cycle maximum.
REQ-013 Push allowed when FIFO count < FIFO_DEPTH, or when count = FIFO_DEPTH and a pop occurs in the same cycle.
REQ-014 Pop occurs when data_valid=1 and data_ack=1; read pointer advances at that edge.
REQ-015 data_out equals FIFO head when data_valid=1, 8'h00 when FIFO empty.
REQ-016 Latency: cmd_req[i] high in cycle N with idle block -> data_valid=1 with data_out=i+1 in cycle N+2.
REQ-017 FIFO order is push order; bytes are never dropped, duplicated, or reordered.
REQ-018 Multiple bits in one cmd_req pulse are pushed lowest index first, one per cycle.
REQ-019 cmd_req[i]=1 while pending[i] already set and not being cleared this cycle -> overrun set to 1; pending[i] stays 1 (request merged, single byte emitted).
REQ-020 cmd_req[i]=1 in the same cycle pending[i] is cleared by a push -> pending[i] remains 1, no overrun.
REQ-021 clr_err and a new overrun event in the same cycle -> overrun=1 (set wins).
REQ-022 Pointers wrap modulo FIFO_DEPTH; count range 0..FIFO_DEPTH, width clog2(FIFO_DEPTH)+1.
REQ-023 Pending bits never lost while FIFO full; they wait until push allowed.

Reset
REQ-024 reset=1 at an edge: pending=0, FIFO pointers and count=0, data_valid=0, data_out=8'h00, busy=0, overrun=0.
REQ-025 reset overrides all concurrent cmd_req, data_ack, clr_err in that cycle; in-flight bytes and pending requests discarded.

Structure
REQ-026 Shared package/include holds NUM_CMDS=16, OPC_WIDTH=8, OPC_MIN=8'h01, OPC_MAX=8'h10, and the index-to-opcode mapping constant.
REQ-027 FIFO implemented as sub-module cmd_fifo (synchronous, same clk/reset, width OPC_WIDTH, depth FIFO_DEPTH); priority pick and pending logic live in command_encoder.

Verification
REQ-028 Idle, data_ack=1, cmd_req=16'h0001 in cycle 0 -> data_valid=1, data_out=8'h01 in cycle 2 only; busy low from cycle 3.
REQ-029 data_ack=0, cmd_req=16'h8005 one cycle -> FIFO holds 8'h01,8'h03,8'h10; then data_ack=1 -> bytes emitted in that order, busy falls after last pop.
REQ-030 data_ack=0, requests on bits 0,1,2,3,4 -> FIFO full with 8'h01..8'h04, pending=16'h0010, busy=1; single pop -> 8'h05 pushed in that same cycle, count stays 4.
REQ-031 FIFO full, pending[6] set, cmd_req=16'h0040 again -> overrun=1, only one 8'h07 later emitted; clr_err pulse -> overrun=0.
REQ-032 FIFO with 3 entries and pending=16'h0100, reset pulse -> next cycle data_valid=0, data_out=8'h00, busy=0, overrun=0; no stale byte emitted afterwards.
